// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// song_sequencer
//
// Steps through a song table held in a synchronous ROM and drives the tone
// channel mux.  Each 8-bit ROM entry is {note[3:0], dur[3:0]}:
//    note 0, 9..14 : rest (silence for the entry's duration)
//    note 1..8     : tone on channel N0..N7 (note_sel = note)
//    note 15       : end marker
//    dur 1..15     : ticks, dur 0 means 16 ticks
// A tick is TICK_DIV clk cycles.  After every note or rest the sequencer
// stays silent for GAP_TICKS ticks, then spends three cycles (ADV, FETCH,
// LOAD) fetching the next entry.
//
// Parameters
//    AW        song ROM address width (2^AW entries)
//    TICK_DIV  clk cycles per duration tick, >= 2
//    GAP_TICKS silent ticks after each entry (0 = legato)
//    TW        prescaler width, must hold TICK_DIV-1
//
// Ports
//    clk       in   system clock
//    rstn      in   asynchronous active-low reset
//    start     in   1-cycle pulse, starts playback at address 0 (IDLE only)
//    stop      in   aborts playback; IDLE on the next cycle, no done pulse
//    loop      in   on the end of the song: 1 = replay from address 0
//    rom_addr  out  song ROM address
//    rom_data  in   ROM word, valid one cycle after rom_addr
//    note_sel  out  channel select, 1..8 = N0..N7, 0 = silence
//    note_en   out  tone gate, mux output forced 0 while low
//    busy      out  high in every state except IDLE
//    done      out  1-cycle pulse on the natural end of the song
//    dbg_state out  current FSM state, for observation only
//
// Handshake: start is a one-cycle request accepted only in IDLE and ignored
// otherwise; stop is a level or pulse that wins over everything else,
// including a start in the same cycle; done is a one-cycle pulse that
// coincides with busy falling.  All outputs are registered.
// ---------------------------------------------------------------------------
module song_sequencer #(
   parameter int AW        = 5,
   parameter int TICK_DIV  = 6000000,
   parameter int GAP_TICKS = 0,
   parameter int TW        = 23
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   output logic [AW-1:0] rom_addr,
   input  logic [7:0]    rom_data,
   output logic [3:0]    note_sel,
   output logic          note_en,
   output logic          busy,
   output logic          done,
   output logic [2:0]    dbg_state
);

   // FSM encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_ADV   = 3'd5;
   localparam logic [2:0] S_END   = 3'd6;

   // The tick counter holds either a note length (up to 16) or the gap
   // length, whichever needs more bits.
   localparam int CW = (GAP_TICKS > 16) ? $clog2(GAP_TICKS + 1) : 5;

   localparam logic [TW-1:0] PRE_LAST  = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS);
   localparam logic          HAS_GAP   = (GAP_TICKS > 0);

   // Registered state
   logic [2:0]    state_q,    state_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [3:0]    note_sel_q, note_sel_d;
   logic          note_en_q,  note_en_d;
   logic          busy_q,     busy_d;
   logic          done_q,     done_d;
   logic [TW-1:0] pre_q,      pre_d;
   logic [CW-1:0] tick_q,     tick_d;

   // Entry decode, meaningful while in LOAD (rom_data then reflects the
   // address that was presented during FETCH).
   logic [3:0]    entry_note;
   logic [3:0]    entry_dur;
   logic          entry_is_end;
   logic          entry_is_tone;
   logic [CW-1:0] entry_ticks;

   // Prescaler / tick counter status, shared by PLAY and GAP
   logic          tick_wrap;
   logic          last_tick;

   always_comb begin
      entry_note    = rom_data[7:4];
      entry_dur     = rom_data[3:0];
      entry_is_end  = (entry_note == 4'd15);
      entry_is_tone = (entry_note != 4'd0) && (entry_note <= 4'd8);
      entry_ticks   = (entry_dur == 4'd0) ? CW'(16) : CW'(entry_dur);
   end

   always_comb begin
      tick_wrap = (pre_q == PRE_LAST);
      last_tick = tick_wrap && (tick_q == CW'(1));
   end

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      note_sel_d = note_sel_q;
      note_en_d  = note_en_q;
      done_d     = 1'b0;
      pre_d      = pre_q;
      tick_d     = tick_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH;
               rom_addr_d = '0;
            end
         end

         // rom_addr is stable for this cycle; the ROM answers in LOAD.
         S_FETCH: begin
            state_d = S_LOAD;
         end

         S_LOAD: begin
            if (entry_is_end) begin
               state_d = S_END;
            end else begin
               tick_d     = entry_ticks;
               pre_d      = '0;
               note_sel_d = entry_is_tone ? entry_note : 4'd0;
               note_en_d  = entry_is_tone;
               state_d    = S_PLAY;
            end
         end

         // The gate drops on the edge that ends the last tick, so note_en
         // is high for exactly ticks*TICK_DIV cycles.
         S_PLAY: begin
            if (tick_wrap) begin
               pre_d  = '0;
               tick_d = tick_q - CW'(1);
               if (last_tick) begin
                  note_en_d  = 1'b0;
                  note_sel_d = 4'd0;
                  if (HAS_GAP) begin
                     tick_d  = GAP_LOAD;
                     state_d = S_GAP;
                  end else begin
                     state_d = S_ADV;
                  end
               end
            end else begin
               pre_d = pre_q + TW'(1);
            end
         end

         S_GAP: begin
            if (tick_wrap) begin
               pre_d  = '0;
               tick_d = tick_q - CW'(1);
               if (last_tick) begin
                  state_d = S_ADV;
               end
            end else begin
               pre_d = pre_q + TW'(1);
            end
         end

         // Running off the top of the ROM is treated as an end marker.
         S_ADV: begin
            if (rom_addr_q == ADDR_LAST) begin
               rom_addr_d = '0;
               if (loop) begin
                  state_d = S_FETCH;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               rom_addr_d = rom_addr_q + AW'(1);
               state_d    = S_FETCH;
            end
         end

         S_END: begin
            rom_addr_d = '0;
            if (loop) begin
               state_d = S_FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d    = S_IDLE;
            rom_addr_d = '0;
            note_sel_d = 4'd0;
            note_en_d  = 1'b0;
         end
      endcase

      // stop overrides every transition above, including a same-cycle start
      // and the done pulse of a song that is ending anyway.
      if (stop) begin
         state_d    = S_IDLE;
         rom_addr_d = '0;
         note_sel_d = 4'd0;
         note_en_d  = 1'b0;
         done_d     = 1'b0;
      end

      // busy is registered from the next state so it tracks the FSM exactly.
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         rom_addr_q <= '0;
         note_sel_q <= 4'd0;
         note_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pre_q      <= '0;
         tick_q     <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         note_sel_q <= note_sel_d;
         note_en_q  <= note_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pre_q      <= pre_d;
         tick_q     <= tick_d;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign note_sel  = note_sel_q;
   assign note_en   = note_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule
